// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - registered ALU with iterative radix-2 multiply/divide
//
// Execute-stage unit. One operation is accepted per in_valid/in_ready handshake
// and its result is presented on y/zero with out_valid held until out_ready.
// Single-cycle ops report one cycle after accept; MUL/MULHU/DIV/DIVU/REM/REMU
// report DATA_WIDTH+1 cycles after accept.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   en         stall; when low every register holds and no handshake completes
//   in_valid   operation request valid
//   in_ready   unit can accept (idle and not stalled)
//   control    4-bit opcode
//   srca/srcb  operands, sampled only at accept
//   out_valid  result valid, held until taken
//   out_ready  consumer takes result
//   y          registered result
//   zero       registered (y == 0), qualified by out_valid
module alu_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            control,
    input  logic [DATA_WIDTH-1:0] srca,
    input  logic [DATA_WIDTH-1:0] srcb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  zero
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int W       = DATA_WIDTH;
    localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W + 1)'(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    // EXEC is the one-cycle evaluation step for single-cycle ops, so that every
    // op reports at least one full cycle after the accept edge.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state;
    logic [3:0]         op_ctl;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;      // divisor magnitude when a divide is in flight
    logic [SHAMT_W:0]   cnt;
    logic [2*W-1:0]     prod;      // {partial sum, remaining multiplier bits}
    logic [W-1:0]       rem;
    logic [W-1:0]       quo;       // dividend bits shift out as quotient bits shift in
    logic               neg_q;
    logic               neg_r;

    assign in_ready = (state == IDLE) && en;

    // Operand magnitudes for the divider, computed from the live inputs so they
    // can be latched on the accept edge.
    logic               in_is_div;
    logic               in_signed_div;
    logic [W-1:0]       a_mag;
    logic [W-1:0]       b_mag;

    assign in_is_div     = (control[3:2] == 2'b11);
    assign in_signed_div = in_is_div && !control[0];
    assign a_mag = (in_signed_div && srca[W-1]) ? -srca : srca;
    assign b_mag = (in_signed_div && srcb[W-1]) ? -srcb : srcb;

    // Single-cycle ALU on latched operands.
    logic [SHAMT_W-1:0] shamt;
    logic [W-1:0]       alu_res;

    assign shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op_ctl)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: add the multiplicand into the upper half when the next
    // multiplier bit is set, then shift the whole product right by one.
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_res;

    assign mul_sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, op_a} : {(W+1){1'b0}});
    assign mul_res = op_ctl[0] ? prod[2*W-1:W] : prod[W-1:0];

    // Restoring divide step: bring down the next dividend bit and subtract the
    // divisor if it fits (no borrow out of the W+1-bit difference).
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;
    logic         div_fits;
    logic [W-1:0] q_fix;
    logic [W-1:0] r_fix;
    logic [W-1:0] div_res;

    assign div_shift = {rem, quo[W-1]};
    assign div_diff  = div_shift - {1'b0, op_b};
    assign div_fits  = !div_diff[W];
    assign q_fix     = neg_q ? -quo : quo;
    assign r_fix     = neg_r ? -rem : rem;

    // A zero divisor yields all-ones quotient for both signednesses; the
    // unsigned path produces that naturally, the signed path must not negate it.
    // Remainder by zero already equals the dividend after sign fix-up.
    always_comb begin
        div_res = '0;
        if (!op_ctl[1]) begin
            div_res = (op_b == '0) ? {W{1'b1}} : q_fix;
        end else begin
            div_res = r_fix;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            op_ctl    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            y         <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_ctl <= control;
                        op_a   <= srca;
                        op_b   <= in_is_div ? b_mag : srcb;
                        cnt    <= '0;
                        if (!control[3] || control[3:1] == 3'b100) begin
                            state <= EXEC;
                        end else if (control[3:1] == 3'b101) begin
                            prod  <= {{W{1'b0}}, srcb};
                            state <= MUL;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            neg_q <= in_signed_div && (srca[W-1] ^ srcb[W-1]);
                            neg_r <= in_signed_div && srca[W-1];
                            state <= DIV;
                        end
                    end
                end
                EXEC: begin
                    y         <= alu_res;
                    zero      <= (alu_res == '0);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                MUL: begin
                    if (cnt == CNT_LAST) begin
                        y         <= mul_res;
                        zero      <= (mul_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        prod <= {mul_sum, prod[W-1:1]};
                        cnt  <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (cnt == CNT_LAST) begin
                        y         <= div_res;
                        zero      <= (div_res == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem <= div_fits ? div_diff[W-1:0] : div_shift[W-1:0];
                        quo <= {quo[W-2:0], div_fits};
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed self-checking bench for alu_muldiv
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  control;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .srca      (srca),
        .srcb      (srcb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero)
    );

    // Present an op and hold it until accepted; returns 1ns after the accept edge
    // with the operand inputs scrambled.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        control  = c;
        srca     = a;
        srcb     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        srca     = 32'hDEAD_BEEF;
        srcb     = 32'h1234_5678;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] yo, output logic zo, output int cyc);
        issue(c, a, b);
        wait_done(cyc);
        yo = y;
        zo = zero;
        take();
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        control = 4'h0; srca = '0; srcb = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (y !== 32'h0) begin bad++; $display("FAIL reset_y: got %h want 00000000", y); end
        total++;
        if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", zero); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        rstn = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_alu();
        logic [3:0]  tc [0:12];
        logic [31:0] ta [0:12];
        logic [31:0] tb [0:12];
        logic [31:0] te [0:12];
        logic [31:0] yo;
        logic        zo;
        int          cyc;
        tc[0]  = 4'h0; ta[0]  = 32'h7FFF_FFFF; tb[0]  = 32'h0000_0001; te[0]  = 32'h8000_0000;
        tc[1]  = 4'h1; ta[1]  = 32'h0000_0005; tb[1]  = 32'h0000_0005; te[1]  = 32'h0000_0000;
        tc[2]  = 4'h2; ta[2]  = 32'hF0F0_1234; tb[2]  = 32'h0FF0_FFFF; te[2]  = 32'h00F0_1234;
        tc[3]  = 4'h3; ta[3]  = 32'hF000_0000; tb[3]  = 32'h0000_000F; te[3]  = 32'hF000_000F;
        tc[4]  = 4'h4; ta[4]  = 32'hFFFF_0000; tb[4]  = 32'hFF00_FF00; te[4]  = 32'h00FF_FF00;
        tc[5]  = 4'h5; ta[5]  = 32'hFFFF_FFFF; tb[5]  = 32'h0000_0001; te[5]  = 32'h0000_0001;
        tc[6]  = 4'h6; ta[6]  = 32'hFFFF_FFFF; tb[6]  = 32'h0000_0001; te[6]  = 32'h0000_0000;
        tc[7]  = 4'h9; ta[7]  = 32'h8000_0000; tb[7]  = 32'h0000_0021; te[7]  = 32'hC000_0000;
        tc[8]  = 4'h7; ta[8]  = 32'h0000_0001; tb[8]  = 32'h0000_0024; te[8]  = 32'h0000_0010;
        tc[9]  = 4'h8; ta[9]  = 32'h8000_0000; tb[9]  = 32'h0000_001F; te[9]  = 32'h0000_0001;
        tc[10] = 4'h5; ta[10] = 32'h0000_0001; tb[10] = 32'hFFFF_FFFF; te[10] = 32'h0000_0000;
        tc[11] = 4'h6; ta[11] = 32'h0000_0001; tb[11] = 32'hFFFF_FFFF; te[11] = 32'h0000_0001;
        tc[12] = 4'h1; ta[12] = 32'h0000_0000; tb[12] = 32'h0000_0001; te[12] = 32'hFFFF_FFFF;
        for (int i = 0; i < 13; i++) begin
            run_op(tc[i], ta[i], tb[i], yo, zo, cyc);
            total++;
            if (yo !== te[i]) begin
                bad++;
                $display("FAIL alu_y[%0d] op=%h: got %h want %h", i, tc[i], yo, te[i]);
            end
            total++;
            if (zo !== (te[i] == 32'h0)) begin
                bad++;
                $display("FAIL alu_zero[%0d]: got %b want %b", i, zo, (te[i] == 32'h0));
            end
            total++;
            if (cyc != 1) begin
                bad++;
                $display("FAIL alu_latency[%0d]: got %0d want 1", i, cyc);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  tc [0:18];
        logic [31:0] ta [0:18];
        logic [31:0] tb [0:18];
        logic [31:0] te [0:18];
        logic [31:0] yo;
        logic        zo;
        int          cyc;
        tc[0]  = 4'hA; ta[0]  = 32'hFFFF_FFFF; tb[0]  = 32'hFFFF_FFFF; te[0]  = 32'h0000_0001;
        tc[1]  = 4'hB; ta[1]  = 32'hFFFF_FFFF; tb[1]  = 32'hFFFF_FFFF; te[1]  = 32'hFFFF_FFFE;
        tc[2]  = 4'hA; ta[2]  = 32'h1234_5678; tb[2]  = 32'h0000_0010; te[2]  = 32'h2345_6780;
        tc[3]  = 4'hB; ta[3]  = 32'h1234_5678; tb[3]  = 32'h0000_0010; te[3]  = 32'h0000_0001;
        tc[4]  = 4'hA; ta[4]  = 32'h0000_0003; tb[4]  = 32'hFFFF_FFFE; te[4]  = 32'hFFFF_FFFA;
        tc[5]  = 4'hA; ta[5]  = 32'h0000_0000; tb[5]  = 32'h0000_0005; te[5]  = 32'h0000_0000;
        tc[6]  = 4'hC; ta[6]  = 32'hFFFF_FFF9; tb[6]  = 32'h0000_0002; te[6]  = 32'hFFFF_FFFD;
        tc[7]  = 4'hE; ta[7]  = 32'hFFFF_FFF9; tb[7]  = 32'h0000_0002; te[7]  = 32'hFFFF_FFFF;
        tc[8]  = 4'hD; ta[8]  = 32'h0000_0007; tb[8]  = 32'h0000_0000; te[8]  = 32'hFFFF_FFFF;
        tc[9]  = 4'hF; ta[9]  = 32'h0000_0007; tb[9]  = 32'h0000_0000; te[9]  = 32'h0000_0007;
        tc[10] = 4'hC; ta[10] = 32'h8000_0000; tb[10] = 32'hFFFF_FFFF; te[10] = 32'h8000_0000;
        tc[11] = 4'hE; ta[11] = 32'h8000_0000; tb[11] = 32'hFFFF_FFFF; te[11] = 32'h0000_0000;
        tc[12] = 4'hC; ta[12] = 32'hFFFF_FFF9; tb[12] = 32'h0000_0000; te[12] = 32'hFFFF_FFFF;
        tc[13] = 4'hE; ta[13] = 32'hFFFF_FFF9; tb[13] = 32'h0000_0000; te[13] = 32'hFFFF_FFF9;
        tc[14] = 4'hD; ta[14] = 32'h0000_0064; tb[14] = 32'h0000_0007; te[14] = 32'h0000_000E;
        tc[15] = 4'hF; ta[15] = 32'h0000_0064; tb[15] = 32'h0000_0007; te[15] = 32'h0000_0002;
        tc[16] = 4'hC; ta[16] = 32'h0000_0007; tb[16] = 32'hFFFF_FFFE; te[16] = 32'hFFFF_FFFD;
        tc[17] = 4'hE; ta[17] = 32'h0000_0007; tb[17] = 32'hFFFF_FFFE; te[17] = 32'h0000_0001;
        tc[18] = 4'hD; ta[18] = 32'hFFFF_FFFF; tb[18] = 32'h0000_0002; te[18] = 32'h7FFF_FFFF;
        for (int i = 0; i < 19; i++) begin
            run_op(tc[i], ta[i], tb[i], yo, zo, cyc);
            total++;
            if (yo !== te[i]) begin
                bad++;
                $display("FAIL muldiv_y[%0d] op=%h: got %h want %h", i, tc[i], yo, te[i]);
            end
            total++;
            if (zo !== (te[i] == 32'h0)) begin
                bad++;
                $display("FAIL muldiv_zero[%0d]: got %b want %b", i, zo, (te[i] == 32'h0));
            end
            total++;
            if (cyc != 33) begin
                bad++;
                $display("FAIL muldiv_latency[%0d]: got %0d want 33", i, cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        issue(4'h0, 32'd1, 32'd2);
        wait_done(cyc);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_start: got %b want 1", out_valid); end
        control = 4'h1; srca = 32'd9; srcb = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            total++;
            if (y !== 32'd3) begin bad++; $display("FAIL bp_y[%0d]: got %h want 00000003", i, y); end
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        take();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_taken: got %b want 0", out_valid); end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_busy_ignored: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        int cyc;
        issue(4'hD, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        wait_done(cyc);
        total++;
        if (cyc != 28) begin bad++; $display("FAIL stall_latency: got %0d want 28 (36 total)", cyc); end
        total++;
        if (y !== 32'd14) begin bad++; $display("FAIL stall_y: got %h want 0000000e", y); end
        en = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_valid: got %b want 1", out_valid); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        en = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int          stale;
        int          cyc;
        logic [31:0] yo;
        logic        zo;
        issue(4'hA, 32'h0000_0123, 32'h0000_0456);
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        total++;
        if (y !== 32'h0) begin bad++; $display("FAIL midrst_y: got %h want 00000000", y); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        total++;
        if (zero !== 1'b1) begin bad++; $display("FAIL midrst_zero: got %b want 1", zero); end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        total++;
        if (stale != 0) begin bad++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale); end
        run_op(4'h0, 32'd2, 32'd3, yo, zo, cyc);
        total++;
        if (yo !== 32'd5) begin bad++; $display("FAIL midrst_add_y: got %h want 00000005", yo); end
        total++;
        if (cyc != 1) begin bad++; $display("FAIL midrst_add_latency: got %0d want 1", cyc); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
